// File: rtl/addsub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational ripple-carry adder for one digit; also exposes the carry into the MSB.
module digit_adder #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT:0] c;

  // Ripple the carry through DIGIT full adders.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(DIGIT); i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign cout = c[DIGIT];
  assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub_unit.sv
// Digit-serial adder/subtractor with start/done handshake, status flags and accumulate mode.
module serial_addsub_unit
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic             acc_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             borrow_o,
  output logic             overflow_o,
  output logic             zero_o
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = clog2(NDIG);

  if ((WIDTH % DIGIT) != 0) begin : g_width_check
    $error("serial_addsub_unit: WIDTH must be a multiple of DIGIT");
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr, r_next;
  logic             carry_q, sub_q;
  logic [DIGIT-1:0] dsum;
  logic             dcout, dcmsb;
  logic             last_dig;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a    (a_sr[DIGIT-1:0]),
    .b    (b_sr[DIGIT-1:0]),
    .cin  (carry_q),
    .s    (dsum),
    .cout (dcout),
    .cmsb (dcmsb)
  );

  // New digit enters at the MSB end; after NDIG digits the register holds the result.
  assign r_next   = (r_sr >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
  assign last_dig = (cnt_q == CW'(NDIG - 1));

  // State register plus registered handshake outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_o <= 1'b1;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_o <= (state_d == IDLE);
      done_o  <= (state_d == DONE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (last_dig) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand/result shift registers, digit counter, carry and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      r_sr       <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      sub_q      <= 1'b0;
      sum_o      <= '0;
      carry_o    <= 1'b0;
      borrow_o   <= 1'b0;
      overflow_o <= 1'b0;
      zero_o     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            a_sr    <= acc_i ? sum_o : a_i;
            b_sr    <= b_i ^ {WIDTH{sub_i}};
            carry_q <= sub_i;
            sub_q   <= sub_i;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          a_sr    <= a_sr >> DIGIT;
          b_sr    <= b_sr >> DIGIT;
          r_sr    <= r_next;
          carry_q <= dcout;
          cnt_q   <= cnt_q + CW'(1);
          if (last_dig) begin
            sum_o      <= r_next;
            carry_o    <= dcout;
            borrow_o   <= sub_q & ~dcout;
            overflow_o <= dcmsb ^ dcout;
            zero_o     <= (r_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Directed self-checking bench for serial_addsub_unit (WIDTH=16, DIGIT=4).
module tb_serial_addsub_unit;

  logic        clk;
  logic        rst_n;
  logic        start_i, sub_i, acc_i;
  logic [15:0] a_i, b_i;
  logic        ready_o, done_o;
  logic [15:0] sum_o;
  logic        carry_o, borrow_o, overflow_o, zero_o;

  int total = 0;
  int bad   = 0;

  serial_addsub_unit #(.WIDTH(16), .DIGIT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .sub_i      (sub_i),
    .acc_i      (acc_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .ready_o    (ready_o),
    .done_o     (done_o),
    .sum_o      (sum_o),
    .carry_o    (carry_o),
    .borrow_o   (borrow_o),
    .overflow_o (overflow_o),
    .zero_o     (zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation at a falling edge and wait (bounded) for done_o.
  task automatic run_op(input logic s, input logic acc, input logic [15:0] a, input logic [15:0] b,
                        output int cyc, output bit ok);
    @(negedge clk);
    start_i = 1'b1; sub_i = s; acc_i = acc; a_i = a; b_i = b;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1;
    ok  = 1'b0;
    while (cyc < 20) begin
      if (done_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({ready_o, done_o, sum_o, carry_o, borrow_o, overflow_o, zero_o} !== {1'b1, 1'b0, 16'h0, 4'b0000}) begin
      bad++;
      $display("FAIL reset_state: got ready=%b done=%b sum=%h flags=%b%b%b%b, want ready=1 done=0 sum=0000 flags=0000",
               ready_o, done_o, sum_o, carry_o, borrow_o, overflow_o, zero_o);
    end
  endtask

  // 0x1234 + 0x0FFF with exact cycle-by-cycle handshake timing.
  task automatic test_add_timing();
    int done_cyc = -1;
    int ready_cyc = -1;
    @(negedge clk);
    start_i = 1'b1; sub_i = 1'b0; acc_i = 1'b0; a_i = 16'h1234; b_i = 16'h0FFF;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (done_o && done_cyc < 0) done_cyc = k;
      if (ready_o && ready_cyc < 0) ready_cyc = k;
      if (k == 5) begin
        total++;
        if ({sum_o, carry_o, overflow_o, zero_o} !== {16'h2233, 3'b000}) begin
          bad++;
          $display("FAIL add_result: got sum=%h c=%b v=%b z=%b, want sum=2233 c=0 v=0 z=0",
                   sum_o, carry_o, overflow_o, zero_o);
        end
      end
    end
    total++;
    if (done_cyc != 5) begin
      bad++;
      $display("FAIL add_done_cycle: got %0d want 5", done_cyc);
    end
    total++;
    if (ready_cyc != 6) begin
      bad++;
      $display("FAIL add_ready_cycle: got %0d want 6", ready_cyc);
    end
  endtask

  task automatic test_sub_borrow();
    int cyc; bit ok;
    run_op(1'b1, 1'b0, 16'h0005, 16'h0007, cyc, ok);
    total++;
    if (!ok || {sum_o, carry_o, borrow_o, overflow_o, zero_o} !== {16'hFFFE, 4'b0100}) begin
      bad++;
      $display("FAIL sub_5_7: ok=%b got sum=%h c=%b b=%b v=%b z=%b, want sum=fffe c=0 b=1 v=0 z=0",
               ok, sum_o, carry_o, borrow_o, overflow_o, zero_o);
    end
  endtask

  task automatic test_overflow();
    int cyc; bit ok;
    run_op(1'b0, 1'b0, 16'h7FFF, 16'h0001, cyc, ok);
    total++;
    if (!ok || {sum_o, carry_o, overflow_o} !== {16'h8000, 2'b01}) begin
      bad++;
      $display("FAIL add_ovf: ok=%b got sum=%h c=%b v=%b, want sum=8000 c=0 v=1",
               ok, sum_o, carry_o, overflow_o);
    end
    run_op(1'b1, 1'b0, 16'h8000, 16'h0001, cyc, ok);
    total++;
    if (!ok || {sum_o, carry_o, borrow_o, overflow_o} !== {16'h7FFF, 3'b101}) begin
      bad++;
      $display("FAIL sub_ovf: ok=%b got sum=%h c=%b b=%b v=%b, want sum=7fff c=1 b=0 v=1",
               ok, sum_o, carry_o, borrow_o, overflow_o);
    end
  endtask

  // 0xFFFF + 1 wraps; a start pulse mid-RUN must be ignored and sum_o must hold until done.
  task automatic test_wrap_and_ignore();
    int dones = 0;
    bit held_ok = 1'b1;
    logic [15:0] held_bad = 16'h0;
    @(negedge clk);
    start_i = 1'b1; sub_i = 1'b0; acc_i = 1'b0; a_i = 16'hFFFF; b_i = 16'h0001;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 2) begin
        start_i = 1'b1; a_i = 16'h1111; b_i = 16'h1111;
      end else begin
        start_i = 1'b0;
      end
      if (done_o) dones++;
      if (k < 5 && sum_o !== 16'h7FFF) begin
        held_ok = 1'b0;
        held_bad = sum_o;
      end
    end
    total++;
    if (!held_ok) begin
      bad++;
      $display("FAIL sum_hold: got %h before done, want 7fff", held_bad);
    end
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL single_done: got %0d done pulses, want 1", dones);
    end
    total++;
    if ({sum_o, carry_o, overflow_o, zero_o} !== {16'h0000, 3'b101}) begin
      bad++;
      $display("FAIL add_wrap: got sum=%h c=%b v=%b z=%b, want sum=0000 c=1 v=0 z=1",
               sum_o, carry_o, overflow_o, zero_o);
    end
  endtask

  task automatic test_accumulate();
    int cyc; bit ok;
    logic [15:0] exp_sum [3];
    exp_sum[0] = 16'h0003; exp_sum[1] = 16'h0006; exp_sum[2] = 16'h0009;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      run_op(1'b0, 1'b1, 16'hDEAD, 16'h0003, cyc, ok);
      total++;
      if (!ok || sum_o !== exp_sum[i]) begin
        bad++;
        $display("FAIL acc_add%0d: ok=%b got %h want %h", i, ok, sum_o, exp_sum[i]);
      end
    end
    run_op(1'b1, 1'b1, 16'hBEEF, 16'h000A, cyc, ok);
    total++;
    if (!ok || {sum_o, carry_o, borrow_o, overflow_o} !== {16'hFFFF, 3'b010}) begin
      bad++;
      $display("FAIL acc_sub: ok=%b got sum=%h c=%b b=%b v=%b, want sum=ffff c=0 b=1 v=0",
               ok, sum_o, carry_o, borrow_o, overflow_o);
    end
  endtask

  task automatic test_reset_in_run();
    int dones = 0;
    int cyc; bit ok;
    @(negedge clk);
    start_i = 1'b1; sub_i = 1'b0; acc_i = 1'b0; a_i = 16'h1111; b_i = 16'h2222;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({sum_o, carry_o, borrow_o, overflow_o, zero_o, done_o} !== 21'h0) begin
      bad++;
      $display("FAIL rst_clear: got sum=%h flags=%b%b%b%b done=%b, want all 0",
               sum_o, carry_o, borrow_o, overflow_o, zero_o, done_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (ready_o !== 1'b1) begin
      bad++;
      $display("FAIL rst_ready: got %b want 1", ready_o);
    end
    for (int k = 0; k < 8; k++) begin
      if (done_o) dones++;
      @(negedge clk);
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL rst_no_done: got %0d done pulses, want 0", dones);
    end
    run_op(1'b0, 1'b0, 16'h0002, 16'h0003, cyc, ok);
    total++;
    if (!ok || sum_o !== 16'h0005) begin
      bad++;
      $display("FAIL post_rst_add: ok=%b got %h want 0005", ok, sum_o);
    end
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; sub_i = 1'b0; acc_i = 1'b0; a_i = '0; b_i = '0;
    test_reset();
    test_add_timing();
    test_sub_borrow();
    test_overflow();
    test_wrap_and_ignore();
    test_accumulate();
    test_reset_in_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
